// File: rtl/goldschmidt_divider_p_if.sv
// Operand / result bundle of the Goldschmidt divide unit.
// The master side issues operands and start; the slave side returns results and status.
interface goldschmidt_divider_p_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_op;
    logic             start;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             ready;
    logic             div_zero;
    logic             ovf;
    logic [CNT_W-1:0] count;

    modport master (
        output a, b, signed_op, start,
        input  q, r, busy, ready, div_zero, ovf, count
    );

    modport slave (
        input  a, b, signed_op, start,
        output q, r, busy, ready, div_zero, ovf, count
    );
endinterface

// File: rtl/goldschmidt_divider_p.sv
// Exact Goldschmidt divider: quotient and remainder for WIDTH-bit operands,
// unsigned or signed (truncating). Special operands finish one cycle after
// accept; the general path normalises, refines x/y ITER times, then fixes the
// quotient by at most one step using the true remainder.
module goldschmidt_divider_p #(
    parameter int WIDTH = 32,
    parameter int ITER  = 6,
    parameter int CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   clrn,
    goldschmidt_divider_p_if.slave bus
);
    localparam int XW    = 2 * WIDTH;      // fixed-point register width
    localparam int FW    = XW - 1;         // fraction bits (1 integer bit)
    localparam int IDX_W = $clog2(WIDTH);
    localparam int SH_W  = 8;

    localparam logic [WIDTH-1:0] ZERO_W   = WIDTH'(0);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [WIDTH-1:0] ONES_W   = ~WIDTH'(0);
    localparam logic [WIDTH-1:0] MIN_W    = ONE_W << (WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    if ((WIDTH < 8) || (WIDTH > 64)) begin : g_width_chk
        $error("goldschmidt_divider_p: WIDTH must be within 8..64");
    end
    if (ITER < $clog2(WIDTH) + 1) begin : g_iter_chk
        $error("goldschmidt_divider_p: ITER must be at least clog2(WIDTH)+1");
    end
    if (ITER > (1 << CNT_W)) begin : g_cnt_chk
        $error("goldschmidt_divider_p: CNT_W too narrow for ITER");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NORM  = 3'd1,
        S_ITER  = 3'd2,
        S_CORR1 = 3'd3,
        S_CORR2 = 3'd4
    } state_t;

    // Magnitude of v, treating it as two's complement when sgn is set.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            mag = ZERO_W - v;
        end else begin
            mag = v;
        end
    endfunction

    // Index of the most significant set bit (0 for v == 0).
    function automatic logic [IDX_W-1:0] msb_idx(input logic [WIDTH-1:0] v);
        msb_idx = IDX_W'(0);
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                msb_idx = IDX_W'(i);
            end
        end
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] a_r, b_r, ma_r, mb_r, q0_r;
    logic             sop_r, qneg_r, rneg_r;
    logic [XW-1:0]    x_r, y_r;
    logic [SH_W-1:0]  sh_r;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] q_out_r, r_out_r;
    logic             busy_r, ready_r, dz_r, ovf_r;
    logic [CNT_W-1:0] count_r;

    logic [WIDTH-1:0] ma_s, mb_s, fq_s, fr_s;
    logic [IDX_W-1:0] msb_a_s, msb_b_s;
    logic             fast_s, fdz_s, fovf_s;
    logic [XW-1:0]    x0_s, y0_s;
    logic [SH_W-1:0]  sh_s;

    // Decode special operands and normalise the latched operands to [0.5,1).
    always_comb begin
        ma_s    = mag(a_r, sop_r);
        mb_s    = mag(b_r, sop_r);
        msb_a_s = msb_idx(ma_s);
        msb_b_s = msb_idx(mb_s);
        x0_s    = {1'b0, ma_s << (IDX_W'(WIDTH - 1) - msb_a_s), {(WIDTH-1){1'b0}}};
        y0_s    = {1'b0, mb_s << (IDX_W'(WIDTH - 1) - msb_b_s), {(WIDTH-1){1'b0}}};
        // de-normalising shift: FW fraction bits less the exponent difference
        sh_s    = SH_W'(FW) - SH_W'(msb_a_s) + SH_W'(msb_b_s);
        fast_s  = 1'b1;
        fdz_s   = 1'b0;
        fovf_s  = 1'b0;
        fq_s    = ZERO_W;
        fr_s    = ZERO_W;
        if (b_r == ZERO_W) begin
            fq_s  = ONES_W;
            fr_s  = a_r;
            fdz_s = 1'b1;
        end else if (sop_r && (a_r == MIN_W) && (b_r == ONES_W)) begin
            fq_s   = MIN_W;
            fovf_s = 1'b1;
        end else if (ma_s < mb_s) begin
            fr_s = a_r;
        end else if (mb_s == ONE_W) begin
            fq_s = (sop_r && b_r[WIDTH-1]) ? (ZERO_W - a_r) : a_r;
        end else begin
            fast_s = 1'b0;
        end
    end

    logic [XW-1:0] f_s, x_nx_s, y_nx_s;

    // One Goldschmidt step: f = 2 - y, both products truncated at the binary point.
    always_comb begin
        f_s    = XW'(0) - y_r;
        x_nx_s = XW'(({{XW{1'b0}}, x_r} * {{XW{1'b0}}, f_s}) >> FW);
        y_nx_s = XW'(({{XW{1'b0}}, y_r} * {{XW{1'b0}}, f_s}) >> FW);
    end

    logic [WIDTH-1:0] q0_s;
    logic [WIDTH:0]   rem_s;

    // Truncated quotient estimate and its exact remainder in WIDTH+1 signed bits.
    always_comb begin
        q0_s  = WIDTH'(x_r >> sh_r);
        rem_s = {1'b0, ma_r} - ({1'b0, q0_s} * {1'b0, mb_r});
    end

    logic [WIDTH-1:0] qm_s, rm_s, qf_s, rf_s;

    // Single-step quotient correction followed by the sign fix-up.
    always_comb begin
        if (rem_r[WIDTH]) begin
            qm_s = q0_r - ONE_W;
            rm_s = rem_r[WIDTH-1:0] + mb_r;
        end else if (rem_r >= {1'b0, mb_r}) begin
            qm_s = q0_r + ONE_W;
            rm_s = rem_r[WIDTH-1:0] - mb_r;
        end else begin
            qm_s = q0_r;
            rm_s = rem_r[WIDTH-1:0];
        end
        qf_s = qneg_r ? (ZERO_W - qm_s) : qm_s;
        rf_s = rneg_r ? (ZERO_W - rm_s) : rm_s;
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r <= S_IDLE;
            a_r     <= ZERO_W;
            b_r     <= ZERO_W;
            ma_r    <= ZERO_W;
            mb_r    <= ZERO_W;
            q0_r    <= ZERO_W;
            sop_r   <= 1'b0;
            qneg_r  <= 1'b0;
            rneg_r  <= 1'b0;
            x_r     <= XW'(0);
            y_r     <= XW'(0);
            sh_r    <= SH_W'(0);
            rem_r   <= (WIDTH + 1)'(0);
            q_out_r <= ZERO_W;
            r_out_r <= ZERO_W;
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
            dz_r    <= 1'b0;
            ovf_r   <= 1'b0;
            count_r <= CNT_W'(0);
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        sop_r   <= bus.signed_op;
                        ready_r <= 1'b0;
                        dz_r    <= 1'b0;
                        ovf_r   <= 1'b0;
                        count_r <= CNT_W'(0);
                        state_r <= S_NORM;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_NORM: begin
                    if (fast_s) begin
                        q_out_r <= fq_s;
                        r_out_r <= fr_s;
                        dz_r    <= fdz_s;
                        ovf_r   <= fovf_s;
                        ready_r <= 1'b1;
                        state_r <= S_IDLE;
                    end else begin
                        ma_r    <= ma_s;
                        mb_r    <= mb_s;
                        x_r     <= x0_s;
                        y_r     <= y0_s;
                        sh_r    <= sh_s;
                        qneg_r  <= sop_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                        rneg_r  <= sop_r & a_r[WIDTH-1];
                        busy_r  <= 1'b1;
                        state_r <= S_ITER;
                    end
                end
                S_ITER: begin
                    x_r <= x_nx_s;
                    y_r <= y_nx_s;
                    if (count_r == CNT_LAST) begin
                        state_r <= S_CORR1;
                    end else begin
                        count_r <= count_r + CNT_W'(1);
                    end
                end
                S_CORR1: begin
                    q0_r    <= q0_s;
                    rem_r   <= rem_s;
                    state_r <= S_CORR2;
                end
                S_CORR2: begin
                    q_out_r <= qf_s;
                    r_out_r <= rf_s;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.q        = q_out_r;
    assign bus.r        = r_out_r;
    assign bus.busy     = busy_r;
    assign bus.ready    = ready_r;
    assign bus.div_zero = dz_r;
    assign bus.ovf      = ovf_r;
    assign bus.count    = count_r;
endmodule

// File: tb/tb_goldschmidt_divider_p.sv
// Scoreboard bench for goldschmidt_divider_p: a 32-bit/ITER=6 instance with
// directed and random operands, plus a 16-bit/ITER=5 instance with random operands.
module tb_goldschmidt_divider_p;
    localparam int W      = 32;
    localparam int ITER   = 6;
    localparam int CNT_W  = 4;
    localparam int W16    = 16;
    localparam int ITER16 = 5;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        bit          dz;
        bit          ov;
        bit          fast;
        int          stamp;
    } exp_t;

    logic clk = 1'b0;
    logic clrn;
    logic clrn16;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done16 = 1'b0;
    exp_t exp_q[$];
    exp_t exp16_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    goldschmidt_divider_p_if #(.WIDTH(W), .CNT_W(CNT_W)) dif ();
    goldschmidt_divider_p_if #(.WIDTH(W16), .CNT_W(CNT_W)) dif16 ();

    goldschmidt_divider_p #(.WIDTH(W), .ITER(ITER), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .clrn(clrn),
        .bus (dif.slave)
    );

    goldschmidt_divider_p #(.WIDTH(W16), .ITER(ITER16), .CNT_W(CNT_W)) dut16 (
        .clk (clk),
        .clrn(clrn16),
        .bus (dif16.slave)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer division with the special-case rules layered on top.
    function automatic exp_t ref_div(input int w, input logic [63:0] a, input logic [63:0] b, input bit s);
        exp_t        e;
        logic [63:0] mask;
        logic [63:0] sbit;
        longint      sa;
        longint      sb;
        longint      ma;
        longint      mb;
        mask = (64'd1 << w) - 64'd1;
        sbit = 64'd1 << (w - 1);
        sa   = (s && a[w-1]) ? $signed(a | ~mask) : $signed(a);
        sb   = (s && b[w-1]) ? $signed(b | ~mask) : $signed(b);
        ma   = (sa < 0) ? -sa : sa;
        mb   = (sb < 0) ? -sb : sb;
        e.dz   = (b == 64'd0);
        e.ov   = s && (a == sbit) && (b == mask);
        e.fast = e.dz || e.ov || (ma < mb) || (mb == 64'sd1);
        e.stamp = 0;
        if (e.dz) begin
            e.q = mask;
            e.r = a;
        end else if (e.ov) begin
            e.q = sbit;
            e.r = 64'd0;
        end else begin
            e.q = $unsigned(sa / sb) & mask;
            e.r = $unsigned(sa % sb) & mask;
        end
        return e;
    endfunction

    // Operand generator biased towards boundaries (0, all ones, MIN, 1, small and small-negative).
    function automatic logic [63:0] rnd(input int w);
        logic [63:0] mask;
        logic [63:0] v;
        mask = (64'd1 << w) - 64'd1;
        v    = {$urandom, $urandom} & mask;
        case ($urandom_range(0, 9))
            0:       v = 64'd0;
            1:       v = mask;
            2:       v = 64'd1 << (w - 1);
            3:       v = 64'd1;
            4, 5:    v = v >> $urandom_range(0, w - 1);
            6:       v = (mask - (v >> $urandom_range(1, w - 1))) & mask;
            default: v = v;
        endcase
        return v;
    endfunction

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input bit s);
        exp_t e;
        e = ref_div(W, a, b, s);
        dif.a         = a[W-1:0];
        dif.b         = b[W-1:0];
        dif.signed_op = s;
        dif.start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dif.start = 1'b0;
        e.stamp   = cyc;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!dif.ready && n < ITER + 8) begin
            @(negedge clk);
            n++;
        end
        if (!dif.ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1 cycle=%0d", cyc);
        end
    endtask

    task automatic run(input logic [63:0] a, input logic [63:0] b, input bit s);
        issue(a, b, s);
        wait_ready();
    endtask

    // Monitor for the 32-bit instance: results, latency, busy span, count and hold.
    initial begin : mon32
        bit          prev_rdy;
        int          busy_cnt;
        logic [63:0] last_q;
        logic [63:0] last_r;
        exp_t        e;
        prev_rdy = 1'b0;
        busy_cnt = 0;
        last_q   = 64'd0;
        last_r   = 64'd0;
        forever begin
            @(negedge clk);
            if (!clrn) begin
                prev_rdy = 1'b0;
                busy_cnt = 0;
                last_q   = 64'd0;
                last_r   = 64'd0;
            end else begin
                if (dif.busy) begin
                    busy_cnt++;
                    chk("hold_q", 64'(dif.q), last_q);
                    chk("hold_r", 64'(dif.r), last_r);
                end
                if (dif.ready && !prev_rdy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready actual=1 required=0 cycle=%0d", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("q", 64'(dif.q), e.q);
                        chk("r", 64'(dif.r), e.r);
                        chk("div_zero", 64'(dif.div_zero), 64'(e.dz));
                        chk("ovf", 64'(dif.ovf), 64'(e.ov));
                        chk("latency", 64'(cyc - e.stamp), e.fast ? 64'd1 : 64'(ITER + 3));
                        chk("busy_cycles", 64'(busy_cnt), e.fast ? 64'd0 : 64'(ITER + 2));
                        chk("count", 64'(dif.count), e.fast ? 64'd0 : 64'(ITER - 1));
                        last_q = e.q;
                        last_r = e.r;
                    end
                    busy_cnt = 0;
                end
                prev_rdy = dif.ready;
            end
        end
    end

    // Monitor for the 16-bit instance: results only.
    initial begin : mon16
        bit   prev_rdy;
        exp_t e;
        prev_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (!clrn16) begin
                prev_rdy = 1'b0;
            end else begin
                if (dif16.ready && !prev_rdy) begin
                    if (exp16_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready16 actual=1 required=0 cycle=%0d", cyc);
                    end else begin
                        e = exp16_q.pop_front();
                        chk("q16", 64'(dif16.q), e.q);
                        chk("r16", 64'(dif16.r), e.r);
                        chk("div_zero16", 64'(dif16.div_zero), 64'(e.dz));
                        chk("ovf16", 64'(dif16.ovf), 64'(e.ov));
                    end
                end
                prev_rdy = dif16.ready;
            end
        end
    end

    // Random driver for the 16-bit instance.
    initial begin : drv16
        exp_t        e;
        logic [63:0] a;
        logic [63:0] b;
        bit          s;
        int          n;
        dif16.a         = '0;
        dif16.b         = '0;
        dif16.signed_op = 1'b0;
        dif16.start     = 1'b0;
        wait (clrn16 === 1'b1);
        @(negedge clk);
        for (int i = 0; i < 3000; i++) begin
            a = rnd(W16);
            b = rnd(W16);
            s = (i >= 1500);
            e = ref_div(W16, a, b, s);
            dif16.a         = a[W16-1:0];
            dif16.b         = b[W16-1:0];
            dif16.signed_op = s;
            dif16.start     = 1'b1;
            @(posedge clk);
            @(negedge clk);
            dif16.start = 1'b0;
            exp16_q.push_back(e);
            n = 0;
            while (!dif16.ready && n < ITER16 + 8) begin
                @(negedge clk);
                n++;
            end
            if (!dif16.ready) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout16 actual=0 required=1 cycle=%0d", cyc);
            end
        end
        @(negedge clk);
        done16 = 1'b1;
    end

    // Watchdog bounding the whole run.
    initial begin : watchdog
        #900000;
        $display("FAIL watchdog actual=running required=finished cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // Main sequence: reset, directed cases, busy-start, mid-flight reset, random sweep.
    initial begin : main_seq
        int n;
        clrn          = 1'b0;
        clrn16        = 1'b0;
        dif.a         = '0;
        dif.b         = '0;
        dif.signed_op = 1'b0;
        dif.start     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_q", 64'(dif.q), 64'd0);
        chk("rst_r", 64'(dif.r), 64'd0);
        chk("rst_busy", 64'(dif.busy), 64'd0);
        chk("rst_ready", 64'(dif.ready), 64'd0);
        chk("rst_count", 64'(dif.count), 64'd0);
        clrn   = 1'b1;
        clrn16 = 1'b1;
        @(negedge clk);

        run(64'd100, 64'd7, 1'b0);
        run(64'hFFFF_FFFF, 64'hFFFF_FFFE, 1'b0);
        run(64'hFFFF_FFFF, 64'd1, 1'b0);
        run(64'hFFFF_FFF9, 64'd2, 1'b1);
        run(64'h8000_0000, 64'hFFFF_FFFF, 1'b1);
        run(64'h1234, 64'd0, 1'b0);
        run(64'd0, 64'd5, 1'b1);
        run(64'd77, 64'hFFFF_FFFF, 1'b1);

        // a start during a busy operation must be ignored
        issue(64'd123456789, 64'd1000, 1'b0);
        repeat (2) @(negedge clk);
        dif.a         = 32'd5;
        dif.b         = 32'd3;
        dif.signed_op = 1'b1;
        dif.start     = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
        wait_ready();

        // reset in the middle of an operation clears everything at once
        issue(64'd1000003, 64'd17, 1'b0);
        repeat (3) @(negedge clk);
        clrn = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(dif.busy), 64'd0);
        chk("mid_rst_ready", 64'(dif.ready), 64'd0);
        chk("mid_rst_q", 64'(dif.q), 64'd0);
        chk("mid_rst_r", 64'(dif.r), 64'd0);
        chk("mid_rst_count", 64'(dif.count), 64'd0);
        chk("mid_rst_dz", 64'(dif.div_zero), 64'd0);
        exp_q.delete();
        @(negedge clk);
        #2;
        clrn = 1'b1;
        @(negedge clk);

        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 2500; i++) begin
                run(rnd(W), rnd(W), m[0]);
            end
        end
        @(negedge clk);
        chk("drain32", 64'(exp_q.size()), 64'd0);

        n = 0;
        while (!done16 && n < 60000) begin
            @(negedge clk);
            n++;
        end
        if (!done16) begin
            checks++;
            errors++;
            $display("FAIL done16_timeout actual=0 required=1 cycle=%0d", cyc);
        end
        chk("drain16", 64'(exp16_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
